// File: rtl/quad_decoder_4bit.sv
// Quadrature A/B decoder driving a 4-bit up/down position count with load and enable.
// Define GLITCH_FILTER_EN to insert a per-phase FILTER_CYCLES-sample filter after the synchronizer.
module quad_decoder_4bit #(
  parameter int unsigned COUNT_MODE    = 4,
  parameter int unsigned FILTER_CYCLES = 3
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iA,
  input  logic       iB,
  input  logic       iEn,
  input  logic       iLoad,
  input  logic [3:0] iPos_in,
  output logic [3:0] oPos,
  output logic       oStep,
  output logic       oUp,
  output logic       oErr
);

  logic [1:0] syncMeta;
  logic [1:0] syncAB;
  logic [1:0] curAB;
  logic [1:0] pAB;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      syncMeta <= 2'b00;
      syncAB   <= 2'b00;
    end else begin
      syncMeta <= {iA, iB};
      syncAB   <= syncMeta;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  for (genvar g = 0; g < 2; g++) begin : gFilt
    logic [CntW-1:0] cntQ;
    logic            levelQ;
    logic            accept;

    // The Fth differing sample is forwarded straight to the decoder so it is
    // decoded on the same edge it is accepted.
    assign accept   = (syncAB[g] != levelQ) && (cntQ == CntW'(FILTER_CYCLES - 1));
    assign curAB[g] = accept ? syncAB[g] : levelQ;

    always_ff @(posedge iClk) begin
      if (iReset) begin
        cntQ   <= '0;
        levelQ <= 1'b0;
      end else if ((syncAB[g] == levelQ) || accept) begin
        cntQ   <= '0;
        levelQ <= curAB[g];
      end else begin
        cntQ   <= cntQ + CntW'(1);
      end
    end
  end
`else
  assign curAB = syncAB;
`endif

  logic isUp;
  logic isDown;
  logic isErr;
  logic isStep;

  always_comb begin
    isUp   = 1'b0;
    isDown = 1'b0;
    case ({pAB, curAB})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: isUp   = 1'b1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: isDown = 1'b1;
      default: ;
    endcase
    isErr = ((pAB ^ curAB) == 2'b11);
    if (COUNT_MODE == 1) begin
      isStep = ({pAB, curAB} == 4'b1000) || ({pAB, curAB} == 4'b0010);
    end else begin
      isStep = isUp | isDown;
    end
  end

  logic [3:0] posQ;
  logic       stepQ;
  logic       upQ;
  logic       errQ;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      pAB   <= 2'b00;
      posQ  <= 4'd0;
      stepQ <= 1'b0;
      upQ   <= 1'b1;
      errQ  <= 1'b0;
    end else begin
      pAB   <= curAB;
      stepQ <= 1'b0;
      errQ  <= isErr;
      if (isUp || isDown) begin
        upQ <= isUp;
      end
      // A load wins over a coincident step; the edge is consumed, not deferred.
      if (iLoad) begin
        posQ <= iPos_in;
      end else if (iEn && isStep) begin
        posQ  <= isUp ? posQ + 4'd1 : posQ - 4'd1;
        stepQ <= 1'b1;
      end
    end
  end

  assign oPos  = posQ;
  assign oStep = stepQ;
  assign oUp   = upQ;
  assign oErr  = errQ;

endmodule
